muldiv_unit: RTL

Iterative multiply/divide unit that sits alongside the ALU in the EX stage of the 5-stage pipelined MIPS core. It executes MULT, MULTU, DIV and DIVU, and holds the architectural HI/LO registers. The EX stage reads HI/LO for MFHI and MFLO and writes them for MTHI and MTLO. While an operation runs, the unit raises `busy` so that hazard logic can freeze IF/ID and ID/EX.

---
 rtl/muldiv_unit.sv | 126 ++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit that holds the architectural HI/LO registers.
// Each operation takes WIDTH shift-add or restoring-divide steps, then one sign-fix cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state_q;
  logic             is_div_q, sa_q, sb_q, bz_q, busy_q, done_q;
  logic [WIDTH-1:0] a_q, m_q, hi_q, lo_q;
  logic [2*WIDTH:0] acc_q;
  logic [CW-1:0]    cnt_q;

  // Operand magnitudes; the sign flags are zero for unsigned ops.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  always_comb begin
    a_neg = ~op[0] & a[WIDTH-1];
    b_neg = ~op[0] & b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  // One iteration; acc holds {upper(W+1), lower(W)} for both algorithms.
  logic [2*WIDTH:0] acc_d, sh;
  logic [WIDTH:0]   trial, upper;
  always_comb begin
    sh    = {acc_q[2*WIDTH-1:0], 1'b0};
    trial = sh[2*WIDTH:WIDTH] - {1'b0, m_q};
    upper = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
    if (is_div_q)
      acc_d = trial[WIDTH] ? sh : {trial, sh[WIDTH-1:1], 1'b1};
    else
      acc_d = {upper, acc_q[WIDTH-1:0]} >> 1;
  end

  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   q_s, r_s, fix_hi_d, fix_lo_d;
  always_comb begin
    prod_s = (sa_q ^ sb_q) ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
    q_s    = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    r_s    = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    if (!is_div_q) begin
      fix_hi_d = prod_s[2*WIDTH-1:WIDTH];
      fix_lo_d = prod_s[WIDTH-1:0];
    end else if (bz_q) begin
      fix_hi_d = a_q;
      fix_lo_d = '1;
    end else begin
      fix_hi_d = r_s;
      fix_lo_d = q_s;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      bz_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      a_q      <= '0;
      m_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (hi_we) hi_q <= wd;
          if (lo_we) lo_q <= wd;
          if (start) begin
            is_div_q <= op[1];
            sa_q     <= a_neg;
            sb_q     <= b_neg;
            bz_q     <= (b == '0);
            a_q      <= a;
            m_q      <= op[1] ? b_mag : a_mag;
            acc_q    <= {{(WIDTH+1){1'b0}}, (op[1] ? a_mag : b_mag)};
            cnt_q    <= CW'(WIDTH);
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_q <= FIX;
        end
        FIX: begin
          hi_q    <= fix_hi_d;
          lo_q    <= fix_lo_d;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
endmodule
